// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: 16 words loaded, ROUNDS words W_t emitted. Optional abort: SHA256_SCHED_ABORT_EN.
// Latency: first W_t is valid the cycle after word 15 is accepted; then one word per cycle.
// Backpressure: w_ready=0 freezes the window and outputs; in_ready is low while emitting.
module sha256_msg_sched #(
  parameter int ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst,
`ifdef SHA256_SCHED_ABORT_EN
  input  logic        abort,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_word,
  output logic [5:0]  w_idx,
  output logic        w_last,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  state_t      state, state_nxt;
  logic [31:0] win [16];
  logic [3:0]  cnt;
  logic [5:0]  t;
  logic        rdy_int;
  logic        load_fire;
  logic        emit_fire;
  logic        abort_fire;
  logic [31:0] w_next;

  function automatic logic [31:0] s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

`ifdef SHA256_SCHED_ABORT_EN
  assign abort_fire = abort;
`else
  assign abort_fire = 1'b0;
`endif

  assign w_next = s1(win[14]) + win[9] + s0(win[1]) + win[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rdy_int   = 1'b0;
    w_valid   = 1'b0;
    load_fire = 1'b0;
    emit_fire = 1'b0;
    case (state)
      IDLE: begin
        rdy_int = 1'b1;
        if (in_valid) begin
          load_fire = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        rdy_int = 1'b1;
        if (in_valid) begin
          load_fire = 1'b1;
          if (cnt == 4'd15) state_nxt = EMIT;
        end
      end
      EMIT: begin
        w_valid = 1'b1;
        if (w_ready) begin
          emit_fire = 1'b1;
          if (t == LAST_IDX) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Abort wins over any handshake in the same cycle.
    if (abort_fire) begin
      state_nxt = IDLE;
      load_fire = 1'b0;
      emit_fire = 1'b0;
    end
  end

  // Loading and emitting share one shift path; only the word entering win[15] differs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
      t   <= 6'd0;
      for (int k = 0; k < 16; k++) win[k] <= 32'd0;
    end else if (abort_fire) begin
      cnt <= 4'd0;
      t   <= 6'd0;
    end else begin
      if (load_fire || emit_fire) begin
        for (int k = 0; k < 15; k++) win[k] <= win[k+1];
        win[15] <= load_fire ? in_word : w_next;
      end
      if (load_fire) cnt <= cnt + 4'd1;
      if (emit_fire) t <= (t == LAST_IDX) ? 6'd0 : t + 6'd1;
    end
  end

  assign in_ready = rdy_int & ~rst;
  assign w_word   = win[0];
  assign w_idx    = t;
  assign w_last   = (state == EMIT) && (t == LAST_IDX);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Bench for sha256_msg_sched against a plain-arithmetic SHA-256 schedule model.
// Define SHA256_SCHED_ABORT_EN to also exercise the abort input.
module tb_sha256_msg_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_word = 32'd0;
  logic        w_ready = 1'b0;
  logic        in_ready, w_valid, w_last, busy;
  logic [31:0] w_word;
  logic [5:0]  w_idx;
`ifdef SHA256_SCHED_ABORT_EN
  logic        abort = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] blk [16];
  logic [31:0] ref_w [64];
  logic [31:0] got_w [64];
  logic [5:0]  got_idx [64];
  logic        got_last [64];
  int n_got, stall_bad, rdy_bad, first_vld_cyc, last_hs_cyc, acc0_cyc, acc15_cyc, load_to;

  sha256_msg_sched #(.ROUNDS(64)) dut (
    .clk(clk), .rst(rst),
`ifdef SHA256_SCHED_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .w_valid(w_valid), .w_ready(w_ready), .w_word(w_word),
    .w_idx(w_idx), .w_last(w_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // FIPS 180-4 schedule recurrence over the whole 64-word array.
  task automatic compute_ref();
    for (int i = 0; i < 16; i++) ref_w[i] = blk[i];
    for (int i = 16; i < 64; i++)
      ref_w[i] = (rotr(ref_w[i-2], 17) ^ rotr(ref_w[i-2], 19) ^ (ref_w[i-2] >> 10))
               + ref_w[i-7]
               + (rotr(ref_w[i-15], 7) ^ rotr(ref_w[i-15], 18) ^ (ref_w[i-15] >> 3))
               + ref_w[i-16];
  endtask

  task automatic rand_block();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
  endtask

  task automatic abc_block();
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  // Offers blk[0..15]; acceptance cycles are recorded at sample time.
  task automatic load_block(input bit gaps);
    int guard;
    load_to = 0;
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        int g;
        g = int'($urandom_range(0, 3));
        repeat (g) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_word  = blk[i];
      guard = 0;
      while (in_ready !== 1'b1 && guard < 50) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 50) load_to++;
      if (i == 0)  acc0_cyc  = cyc;
      if (i == 15) acc15_cyc = cyc;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_word  = $urandom;
  endtask

  // Drains n schedule words; optional random stalls and junk on the input side.
  task automatic collect(input int n, input bit rnd, input bit noise);
    bit pst;
    logic [31:0] pw;
    logic [5:0] pi;
    logic pl;
    int guard;
    n_got = 0; stall_bad = 0; rdy_bad = 0; first_vld_cyc = -1;
    pst = 1'b0; pw = 32'd0; pi = 6'd0; pl = 1'b0; guard = 0;
    while (n_got < n && guard < 2000) begin
      if (pst && (w_valid !== 1'b1 || w_word !== pw || w_idx !== pi || w_last !== pl))
        stall_bad++;
      if (w_valid === 1'b1 && in_ready !== 1'b0) rdy_bad++;
      if (w_valid === 1'b1 && first_vld_cyc < 0) first_vld_cyc = cyc;
      w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_word  = $urandom;
      end
      pst = (w_valid === 1'b1) && !w_ready;
      pw = w_word; pi = w_idx; pl = w_last;
      if (w_valid === 1'b1 && w_ready) begin
        got_w[n_got]    = w_word;
        got_idx[n_got]  = w_idx;
        got_last[n_got] = w_last;
        n_got++;
        last_hs_cyc = cyc;
      end
      @(posedge clk); #1;
      guard++;
    end
    w_ready  = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++; if (w_valid !== 1'b0) begin bad++; $display("FAIL rst_w_valid got=%b exp=0", w_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (w_word !== 32'd0) begin bad++; $display("FAIL rst_w_word got=%h exp=0", w_word); end
    total++; if (w_idx !== 6'd0 || w_last !== 1'b0) begin bad++; $display("FAIL rst_idx_last got=%0d/%b exp=0/0", w_idx, w_last); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL idle_after_rst in_ready=%b busy=%b exp=1/0", in_ready, busy); end
  endtask

  task automatic test_abc();
    abc_block();
    compute_ref();
    load_block(1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abc_busy_emit got=%b exp=1", busy); end
    collect(64, 1'b0, 1'b0);
    total++; if (n_got != 64 || load_to != 0) begin bad++; $display("FAIL abc_count got=%0d exp=64 (load timeouts %0d)", n_got, load_to); end
    total++; if (first_vld_cyc != acc15_cyc + 1) begin bad++; $display("FAIL abc_latency got=%0d exp=%0d", first_vld_cyc, acc15_cyc + 1); end
    total++; if (got_w[16] !== 32'h61626380) begin bad++; $display("FAIL abc_w16 got=%h exp=61626380", got_w[16]); end
    total++; if (got_w[17] !== 32'h000F0000) begin bad++; $display("FAIL abc_w17 got=%h exp=000f0000", got_w[17]); end
    total++; if (got_w[18] !== 32'h7DA86405) begin bad++; $display("FAIL abc_w18 got=%h exp=7da86405", got_w[18]); end
    total++; if (got_w[63] !== 32'h12B1EDEB) begin bad++; $display("FAIL abc_w63 got=%h exp=12b1edeb", got_w[63]); end
    for (int i = 0; i < 64; i++) begin
      total++;
      if (got_w[i] !== ref_w[i] || got_idx[i] !== 6'(i) || got_last[i] !== (i == 63)) begin
        bad++;
        $display("FAIL abc_seq[%0d] got=%h/%0d/%b exp=%h/%0d/%b", i, got_w[i], got_idx[i], got_last[i], ref_w[i], i, i == 63);
      end
    end
    total++; if (w_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL abc_end w_valid=%b busy=%b exp=0/0", w_valid, busy); end
  endtask

  task automatic test_stall();
    abc_block();
    compute_ref();
    load_block(1'b0);
    collect(64, 1'b1, 1'b1);
    total++; if (n_got != 64) begin bad++; $display("FAIL stall_count got=%0d exp=64", n_got); end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL stall_hold unstable_cycles=%0d exp=0", stall_bad); end
    total++; if (rdy_bad != 0) begin bad++; $display("FAIL stall_in_ready_in_emit cycles=%0d exp=0", rdy_bad); end
    for (int i = 0; i < 64; i++) begin
      total++;
      if (got_w[i] !== ref_w[i] || got_idx[i] !== 6'(i)) begin
        bad++;
        $display("FAIL stall_seq[%0d] got=%h/%0d exp=%h/%0d", i, got_w[i], got_idx[i], ref_w[i], i);
      end
    end
  endtask

  task automatic test_gaps();
    rand_block();
    compute_ref();
    load_block(1'b1);
    collect(64, 1'b0, 1'b0);
    total++; if (n_got != 64 || load_to != 0) begin bad++; $display("FAIL gaps_count got=%0d exp=64", n_got); end
    total++; if (first_vld_cyc != acc15_cyc + 1) begin bad++; $display("FAIL gaps_latency got=%0d exp=%0d", first_vld_cyc, acc15_cyc + 1); end
    for (int i = 0; i < 64; i++) begin
      total++;
      if (got_w[i] !== ref_w[i]) begin
        bad++;
        $display("FAIL gaps_seq[%0d] got=%h exp=%h", i, got_w[i], ref_w[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    rand_block();
    load_block(1'b0);
    collect(30, 1'b0, 1'b0);
    total++; if (w_valid !== 1'b1 || w_idx !== 6'd30) begin bad++; $display("FAIL mid_idx got=%b/%0d exp=1/30", w_valid, w_idx); end
    rst = 1'b1;
    #1;
    total++; if (w_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ctl got=%b/%b/%b exp=0/0/0", w_valid, busy, in_ready); end
    total++; if (w_word !== 32'd0 || w_idx !== 6'd0) begin bad++; $display("FAIL mid_rst_data got=%h/%0d exp=0/0", w_word, w_idx); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    load_block(1'b0);
    collect(64, 1'b0, 1'b0);
    total++; if (n_got != 64 || got_idx[0] !== 6'd0) begin bad++; $display("FAIL mid_restart got=%0d/%0d exp=64/0", n_got, got_idx[0]); end
    for (int i = 0; i < 64; i++) begin
      total++;
      if (got_w[i] !== 32'd0) begin
        bad++;
        $display("FAIL mid_zero[%0d] got=%h exp=00000000", i, got_w[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int hs_a;
    rand_block();
    compute_ref();
    load_block(1'b0);
    collect(64, 1'b0, 1'b0);
    hs_a = last_hs_cyc;
    total++; if (rdy_bad != 0) begin bad++; $display("FAIL b2b_rdy_a cycles=%0d exp=0", rdy_bad); end
    for (int i = 0; i < 64; i++) begin
      total++;
      if (got_w[i] !== ref_w[i]) begin bad++; $display("FAIL b2b_a[%0d] got=%h exp=%h", i, got_w[i], ref_w[i]); end
    end
    rand_block();
    compute_ref();
    load_block(1'b0);
    total++; if (acc0_cyc != hs_a + 1) begin bad++; $display("FAIL b2b_accept got=%0d exp=%0d", acc0_cyc, hs_a + 1); end
    collect(64, 1'b0, 1'b0);
    total++; if (rdy_bad != 0) begin bad++; $display("FAIL b2b_rdy_b cycles=%0d exp=0", rdy_bad); end
    for (int i = 0; i < 64; i++) begin
      total++;
      if (got_w[i] !== ref_w[i]) begin bad++; $display("FAIL b2b_b[%0d] got=%h exp=%h", i, got_w[i], ref_w[i]); end
    end
  endtask

`ifdef SHA256_SCHED_ABORT_EN
  task automatic test_abort();
    rand_block();
    load_block(1'b0);
    collect(10, 1'b0, 1'b0);
    total++; if (w_idx !== 6'd10) begin bad++; $display("FAIL abort_pre_idx got=%0d exp=10", w_idx); end
    abort = 1'b1;
    w_ready = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    w_ready = 1'b0;
    total++; if (w_valid !== 1'b0 || busy !== 1'b0 || w_idx !== 6'd0) begin bad++; $display("FAIL abort_state got=%b/%b/%0d exp=0/0/0", w_valid, busy, w_idx); end
    rand_block();
    compute_ref();
    load_block(1'b0);
    collect(64, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      total++;
      if (got_w[i] !== ref_w[i] || got_idx[i] !== 6'(i)) begin bad++; $display("FAIL abort_seq[%0d] got=%h/%0d exp=%h/%0d", i, got_w[i], got_idx[i], ref_w[i], i); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_abc();
    test_stall();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
`ifdef SHA256_SCHED_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha256_msg_sched.md
SHA256_MSG_SCHED -- requirements
Module: sha256_msg_sched

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clock port clk, reset port rst.
REQ-002 SHALL have parameter ROUNDS, default 64, meaning the number of schedule words emitted per block (legal range 16..64).
REQ-003 Ports SHALL be:
  clk  input  1  clock, rising edge
  rst  input  1  asynchronous active-high reset
  in_valid  input  1  message word offered
  in_ready  output  1  block accepts a message word
  in_word  input  32  message word M_i, big-endian word order, i = 0..15
  w_valid  output  1  schedule word available
  w_ready  input  1  consumer accepts schedule word
  w_word  output  32  schedule word W_t
  w_idx  output  6  round index t of w_word
  w_last  output  1  high when w_idx = ROUNDS-1
  busy  output  1  high in LOAD or EMIT

Function
REQ-004 SHALL implement FSM states IDLE, LOAD and EMIT.
REQ-005 IDLE: in_ready=1, w_valid=0; in_valid=1 SHALL store word 0 and move to LOAD.
REQ-006 LOAD: in_ready=1; each in_valid cycle SHALL store the next word; acceptance of word 15 SHALL move to EMIT.
REQ-007 in_ready SHALL be 0 in EMIT; in_valid SHALL be ignored there.
REQ-008 Window: 16 x 32-bit registers win[0..15]; loaded words fill win[0..15] in arrival order.
REQ-009 EMIT: w_valid=1, w_word=win[0], w_idx=t, starting at t=0.
REQ-010 First w_valid SHALL occur in the cycle after word 15 is accepted (latency 1 cycle).
REQ-011 On w_valid && w_ready: window SHALL shift (win[k] <= win[k+1]), win[15] <= s1(win[14]) + win[9] + s0(win[1]) + win[0] modulo 2^32, and t increments.
REQ-012 s0(x) = ROTR7 ^ ROTR18 ^ SHR3; s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
REQ-013 Throughput SHALL be one word per cycle while w_ready=1.
REQ-014 While w_valid=1 and w_ready=0, w_word, w_idx and w_last SHALL hold stable.
REQ-015 Handshake with w_idx=ROUNDS-1 SHALL return the FSM to IDLE; w_valid=0 on the next cycle.
REQ-016 Back-to-back blocks: a word offered in the first IDLE cycle after EMIT SHALL be accepted with no extra bubble.
REQ-017 w_idx SHALL not wrap; no word past ROUNDS-1 is emitted.
REQ-018 busy SHALL be 1 in LOAD and EMIT, 0 in IDLE.

Reset
REQ-019 rst=1 SHALL, independent of clk, force IDLE, t=0, window=0, w_valid=0, w_last=0, w_word=0, w_idx=0, busy=0, in_ready=0 while rst is held.
REQ-020 Reset asserted in LOAD or EMIT SHALL discard the partial block; the first post-reset word is word 0.

Configuration
REQ-021 With macro SHA256_SCHED_ABORT_EN defined, SHALL add input abort (1 bit); abort=1 at a rising edge SHALL return the FSM to IDLE, clear t and deassert w_valid on the next cycle; abort has priority over any simultaneous handshake.
REQ-022 Without SHA256_SCHED_ABORT_EN, the abort port and its logic SHALL not exist; behaviour is otherwise identical.

Verification
REQ-023 Load "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 -> W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W63=0x12B1EDEB with w_last=1 at w_idx=63.
REQ-024 Same block, w_ready toggled randomly -> identical 64-word sequence; w_word stable during every stall.
REQ-025 Words 0..15 offered with in_valid gaps -> first w_valid exactly 1 cycle after word 15 is accepted, W0..W15 echoed unchanged.
REQ-026 Assert rst at w_idx=30, then load all-zero block -> all 64 outputs 0x00000000, w_idx restarts at 0.
REQ-027 Two blocks back-to-back -> second block's word 0 accepted the cycle after W63 handshake; in_ready=0 throughout each EMIT.
REQ-028 With SHA256_SCHED_ABORT_EN, abort at w_idx=10 together with w_ready=1 -> w_valid=0 next cycle, busy=0, next load starts at word 0.
